pipeline_split_n: RTL and testbench
===================================

Name: pipeline_split_n

Overview:
Buffered 1-to-N stream splitter for the pipelined datapath. Accepts one valid/ready input stream, holds it in a DEPTH-entry FIFO, and delivers each beat to NUM_OUT consumers.
- Priority mode: each beat goes to exactly one consumer, the lowest-index ready one, so higher indices act as fallbacks.
- Broadcast mode: each beat goes to every consumer, and each consumer may accept in a different cycle.

Parameters:
DW, 8, data width in bits
NUM_OUT, 2, number of output channels (>=2)
DEPTH, 2, FIFO entries (>=1; 2 or more required for full throughput)
MODE, SPLIT_PRIORITY, split_mode_e: SPLIT_PRIORITY or SPLIT_BROADCAST

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_i  in  1  synchronous reset, active-high
clear_i  in  1  synchronous clear, same effect as rst_i
data_in_i  in  DW  input beat
data_in_valid_i  in  1  input valid
data_in_ready_o  out  1  input ready
data_out_o  out  DW  head beat, shared by all outputs
data_out_valid_o  out  NUM_OUT  per-output valid
data_out_ready_i  in  NUM_OUT  per-output ready
count_o  out  $clog2(DEPTH+1)  entries currently held

Behaviour:
- Reset/clock: one clock, clk_i. Reset is rst_i, synchronous and active-high. clear_i is identical in effect; either one set at a rising edge wins over all other activity in that cycle.
- Reset values: pointers, count and sent mask go to 0. The outputs then read data_in_ready_o=1, data_out_valid_o='0, count_o=0, data_out_o='0.
- data_out_o is '0 whenever the FIFO is empty; FIFO storage itself is not reset.
- Input handshake:
  - data_in_ready_o = (count < DEPTH), a function of registered state only.
  - Push on valid&ready.
  - A pushed beat appears on data_out_o/valid on the next cycle (latency 1).
- Simultaneous push and pop: legal when not full, count unchanged. When full, ready is low, so no push occurs that cycle even if a pop happens.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Occupancy: count_o is bounded 0..DEPTH. Never underflow or overflow.
- SPLIT_PRIORITY:
  - valid[0] = !empty.
  - valid[k] = !empty & ~|ready[k-1:0].
  - This is a combinational ready->valid path, by design.
  - At most one handshake per cycle, to the lowest-index ready output.
  - Pop on any handshake.
- SPLIT_BROADCAST:
  - Per-output sent_q[NUM_OUT] register records which outputs have already taken the head beat.
  - valid[k] = !empty & !sent_q[k]; no ready->valid path.
  - acc = valid & ready.
  - If (sent_q | acc) is all-ones: pop the head and clear sent_q.
  - Otherwise: sent_q <= sent_q | acc.
  - All outputs ready together gives 1 beat/cycle. A stalled output blocks the head while the others stay deasserted after taking it.
- Valid stability: in broadcast mode, once valid[k] is asserted it holds with stable data until that output handshakes. Priority mode guarantees this only for output 0.
- Reset or clear mid-beat: sent_q and the FIFO are discarded with no partial delivery completion. The next cycle shows reset values.
- Assertions (simulation only):
  - no push when full;
  - count_o never exceeds DEPTH;
  - at most one handshake per cycle in priority mode.

Decomposition:
- Package pipeline_split_pkg: typedef enum logic {SPLIT_PRIORITY, SPLIT_BROADCAST} split_mode_e.
- Sub-module split_fifo(DW, DEPTH): storage, pointers, count, push/pop, with the same reset and clear behaviour.
- The top level holds the mode logic, generated per MODE.

Test Plan:
- Reset, idle: assert rst_i for 2 cycles, then release -> data_in_ready_o=1, data_out_valid_o=0, count_o=0, data_out_o=0.
- Priority fallback, NUM_OUT=3, push 0xA5 with ready=3'b110 -> next cycle valid=3'b011; output 1 takes 0xA5; count_o goes 1->0.
- Priority back-pressure, DEPTH=2, all ready low, push 0x11, 0x22, 0x33:
  - data_in_ready_o=0 after 2 beats; count_o=2; 0x33 held off.
  - Then ready[0]=1 -> 0x11, 0x22, 0x33 leave in order.
- Broadcast staggered, NUM_OUT=3, push 0x5C:
  - ready=001 -> valid becomes 110;
  - ready=100 -> valid becomes 010;
  - ready=010 -> pop; count_o=0; sent_q cleared.
- Broadcast throughput: all ready=1, 8 back-to-back beats 0..7 -> each output sees 0..7, one beat per cycle, data_in_ready_o stays 1.
- Clear mid-operation: broadcast with sent_q=010 and count_o=2; pulse clear_i simultaneously with a push -> next cycle count_o=0, valid=0, pushed beat discarded.

Source files
------------

// File: rtl/pipeline_split_pkg.sv
// Shared types for the pipeline_split_n stream splitter.
// split_mode_e selects how each buffered beat is handed to the consumers:
//   SPLIT_PRIORITY  - one consumer per beat, lowest-index ready consumer wins
//   SPLIT_BROADCAST - every consumer receives every beat, at its own pace
package pipeline_split_pkg;

  typedef enum logic {
    SPLIT_PRIORITY  = 1'b0,
    SPLIT_BROADCAST = 1'b1
  } split_mode_e;

endpackage

// File: rtl/pipeline_split_n_fifo.sv
// split_fifo: DEPTH-entry circular FIFO used as the input buffer of
// pipeline_split_n. DEPTH need not be a power of two.
// Ports:
//   clk_i, rst_i, clear_i : clock, synchronous reset and clear (same effect)
//   push_i, data_i        : write request and data (ignored while full)
//   pop_i                 : read request (ignored while empty)
//   data_o                : head entry, forced to zero while empty
//   empty_o, full_o       : occupancy flags
//   count_o               : number of entries held, 0..DEPTH
module split_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [DW-1:0]                data_i,
  input  logic                         pop_i,
  output logic [DW-1:0]                data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  logic w_flush;
  logic w_push;
  logic w_pop;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH-1)) ? '0 : ptr + PW'(1);
  endfunction

  // Requests are qualified here so occupancy can never over- or underflow,
  // and a reset or clear in the same cycle suppresses every transfer.
  always_comb begin
    w_flush = rst_i | clear_i;
    w_push  = push_i & ~full_o & ~w_flush;
    w_pop   = pop_i & ~empty_o & ~w_flush;
  end

  // Pointer and occupancy state; storage itself is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (w_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_pop)  r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Data storage write port.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wrPtr] <= data_i;
  end

  // Flags and head data; the head reads as zero when nothing is buffered.
  always_comb begin
    empty_o = (r_count == '0);
    full_o  = (r_count == CW'(DEPTH));
    count_o = r_count;
    data_o  = empty_o ? '0 : r_mem[r_rdPtr];
  end

  a_noPushWhenFull : assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
    push_i |-> !full_o);
  a_countBounded : assert property (@(posedge clk_i)
    r_count <= CW'(DEPTH));

endmodule

// File: rtl/pipeline_split_n.sv
// pipeline_split_n: buffered 1-to-NUM_OUT stream splitter.
// The input valid/ready stream is buffered in a DEPTH-entry FIFO and the head
// beat is offered to all consumers on a shared data bus.
// Ports:
//   clk_i, rst_i, clear_i           : clock, synchronous reset and clear
//   data_in_i / _valid_i / _ready_o : input stream
//   data_out_o                      : head beat, shared by all outputs
//   data_out_valid_o[NUM_OUT]       : per-output valid
//   data_out_ready_i[NUM_OUT]       : per-output ready
//   count_o                         : entries currently buffered
module pipeline_split_n
  import pipeline_split_pkg::*;
#(
  parameter int          DW      = 8,
  parameter int          NUM_OUT = 2,
  parameter int          DEPTH   = 2,
  parameter split_mode_e MODE    = SPLIT_PRIORITY
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic [DW-1:0]              data_in_i,
  input  logic                       data_in_valid_i,
  output logic                       data_in_ready_o,
  output logic [DW-1:0]              data_out_o,
  output logic [NUM_OUT-1:0]         data_out_valid_o,
  input  logic [NUM_OUT-1:0]         data_out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [NUM_OUT-1:0] w_valid;

  // Ready depends only on registered occupancy, never on the input valid.
  always_comb begin
    data_in_ready_o  = ~w_full;
    w_push           = data_in_valid_i & ~w_full;
    data_out_valid_o = w_valid;
  end

  split_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (w_push),
    .data_i  (data_in_i),
    .pop_i   (w_pop),
    .data_o  (data_out_o),
    .empty_o (w_empty),
    .full_o  (w_full),
    .count_o (count_o)
  );

  generate
    if (MODE == SPLIT_PRIORITY) begin : g_priority
      logic w_lowerReady;

      // Output k is offered the beat only when no lower-index output is
      // ready, so at most one handshake can happen and higher indices act as
      // fallbacks. This creates a deliberate ready->valid combinational path.
      always_comb begin
        w_valid      = '0;
        w_lowerReady = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
          w_valid[k]   = ~w_empty & ~w_lowerReady;
          w_lowerReady = w_lowerReady | data_out_ready_i[k];
        end
        w_pop = |(w_valid & data_out_ready_i);
      end

      a_oneHandshake : assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
        $onehot0(w_valid & data_out_ready_i));

    end else begin : g_broadcast
      logic [NUM_OUT-1:0] r_sent;
      logic [NUM_OUT-1:0] w_acc;
      logic               w_allTaken;

      // Each output sees the head until it has taken it; the head is popped
      // only once every output has it, counting takes in this very cycle.
      always_comb begin
        w_valid    = {NUM_OUT{~w_empty}} & ~r_sent;
        w_acc      = w_valid & data_out_ready_i;
        w_allTaken = &(r_sent | w_acc);
        w_pop      = ~w_empty & w_allTaken;
      end

      // Record which outputs already took the head; restart for the next beat.
      always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
          r_sent <= '0;
        end else if (w_pop) begin
          r_sent <= '0;
        end else begin
          r_sent <= r_sent | w_acc;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipeline_split_n.sv
// Self-checking bench for pipeline_split_n. One priority-mode and one
// broadcast-mode instance (NUM_OUT=3, DEPTH=2) are driven with directed
// vectors. Expected beats are queued when stimulus is issued and monitors
// pop and compare them whenever an output handshakes.
module tb_pipeline_split_n;
  import pipeline_split_pkg::*;

  localparam int DW    = 8;
  localparam int NOUT  = 3;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst;

  logic            pClear, pVin, pRdyO;
  logic [DW-1:0]   pDin, pDout;
  logic [NOUT-1:0] pValid, pRdy;
  logic [CW-1:0]   pCount;

  logic            bClear, bVin, bRdyO;
  logic [DW-1:0]   bDin, bDout;
  logic [NOUT-1:0] bValid, bRdy;
  logic [CW-1:0]   bCount;

  int nVectors     = 0;
  int nMiscompares = 0;

  logic [9:0]    qPri[$];
  logic [DW-1:0] qBc0[$];
  logic [DW-1:0] qBc1[$];
  logic [DW-1:0] qBc2[$];

  logic [NOUT-1:0] pHs;
  logic [9:0]      pExp;
  int              pIdx;

  always #5 clk = ~clk;

  pipeline_split_n #(.DW(DW), .NUM_OUT(NOUT), .DEPTH(DEPTH), .MODE(SPLIT_PRIORITY)) dutPri (
    .clk_i            (clk),
    .rst_i            (rst),
    .clear_i          (pClear),
    .data_in_i        (pDin),
    .data_in_valid_i  (pVin),
    .data_in_ready_o  (pRdyO),
    .data_out_o       (pDout),
    .data_out_valid_o (pValid),
    .data_out_ready_i (pRdy),
    .count_o          (pCount)
  );

  pipeline_split_n #(.DW(DW), .NUM_OUT(NOUT), .DEPTH(DEPTH), .MODE(SPLIT_BROADCAST)) dutBc (
    .clk_i            (clk),
    .rst_i            (rst),
    .clear_i          (bClear),
    .data_in_i        (bDin),
    .data_in_valid_i  (bVin),
    .data_in_ready_o  (bRdyO),
    .data_out_o       (bDout),
    .data_out_valid_o (bValid),
    .data_out_ready_i (bRdy),
    .count_o          (bCount)
  );

  // Single comparison point: counts every check and reports each miscompare.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then let it settle.
  task automatic applyStimulus(input logic pv, input logic [DW-1:0] pd, input logic [NOUT-1:0] pr,
                               input logic bv, input logic [DW-1:0] bd, input logic [NOUT-1:0] br,
                               input logic bc);
    @(posedge clk);
    #1;
    pVin   = pv;
    pDin   = pd;
    pRdy   = pr;
    bVin   = bv;
    bDin   = bd;
    bRdy   = br;
    bClear = bc;
    #1;
  endtask

  task automatic popBroadcast(input int k, input logic [DW-1:0] d);
    logic [DW-1:0] e;
    int sz;
    case (k)
      0:       sz = qBc0.size();
      1:       sz = qBc1.size();
      default: sz = qBc2.size();
    endcase
    if (sz == 0) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL bc_unexpected_beat: output %0d gave 0x%0h, expected no beat", k, d);
    end else begin
      case (k)
        0:       e = qBc0.pop_front();
        1:       e = qBc1.pop_front();
        default: e = qBc2.pop_front();
      endcase
      checkOutput($sformatf("bc_data_out%0d", k), 32'(d), 32'(e));
    end
  endtask

  // Priority monitor: handshakes are sampled mid-cycle, where inputs and
  // combinational outputs are stable ahead of the next rising edge.
  always @(negedge clk) begin
    if (!rst && !pClear) begin
      pHs = pValid & pRdy;
      if (pHs != '0) begin
        checkOutput("pri_single_handshake", 32'($countones(pHs)), 32'd1);
        if (qPri.size() == 0) begin
          nVectors++;
          nMiscompares++;
          $display("[TB] FAIL pri_unexpected_beat: got 0x%0h on mask %b, expected no beat", pDout, pHs);
        end else begin
          pExp = qPri.pop_front();
          pIdx = 0;
          for (int k = NOUT-1; k >= 0; k--) if (pHs[k]) pIdx = k;
          checkOutput("pri_port", 32'(pIdx), 32'(pExp[9:8]));
          checkOutput("pri_data", 32'(pDout), 32'(pExp[7:0]));
        end
      end
    end
  end

  // Broadcast monitor: every output checks its own expected stream.
  always @(negedge clk) begin
    if (!rst && !bClear) begin
      for (int k = 0; k < NOUT; k++) begin
        if (bValid[k] && bRdy[k]) popBroadcast(k, bDout);
      end
    end
  end

  initial begin
    rst = 1'b1; pClear = 1'b0; bClear = 1'b0;
    pVin = 1'b0; pDin = '0; pRdy = '0;
    bVin = 1'b0; bDin = '0; bRdy = '0;

    // Reset held for two edges, then idle values on both instances.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_pri_ready", 32'(pRdyO), 32'd1);
    checkOutput("rst_pri_valid", 32'(pValid), 32'd0);
    checkOutput("rst_pri_count", 32'(pCount), 32'd0);
    checkOutput("rst_pri_data", 32'(pDout), 32'd0);
    checkOutput("rst_bc_ready", 32'(bRdyO), 32'd1);
    checkOutput("rst_bc_valid", 32'(bValid), 32'd0);
    checkOutput("rst_bc_count", 32'(bCount), 32'd0);
    checkOutput("rst_bc_data", 32'(bDout), 32'd0);

    // Priority fallback: output 0 not ready, so output 1 takes 0xA5.
    qPri.push_back({2'd1, 8'hA5});
    applyStimulus(1'b1, 8'hA5, 3'b110, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("fb_count_before", 32'(pCount), 32'd0);
    applyStimulus(1'b0, 8'h00, 3'b110, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("fb_valid", 32'(pValid), 32'b011);
    checkOutput("fb_count", 32'(pCount), 32'd1);
    checkOutput("fb_data", 32'(pDout), 32'hA5);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("fb_count_after", 32'(pCount), 32'd0);
    checkOutput("fb_valid_after", 32'(pValid), 32'd0);

    // Priority back-pressure: FIFO fills at two beats and holds off 0x33.
    qPri.push_back({2'd0, 8'h11});
    qPri.push_back({2'd0, 8'h22});
    qPri.push_back({2'd0, 8'h33});
    applyStimulus(1'b1, 8'h11, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0);
    applyStimulus(1'b1, 8'h22, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("bp_count1", 32'(pCount), 32'd1);
    applyStimulus(1'b1, 8'h33, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("bp_full_ready", 32'(pRdyO), 32'd0);
    checkOutput("bp_full_count", 32'(pCount), 32'd2);
    applyStimulus(1'b1, 8'h33, 3'b001, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("bp_held_count", 32'(pCount), 32'd2);
    checkOutput("bp_held_ready", 32'(pRdyO), 32'd0);
    checkOutput("bp_head", 32'(pDout), 32'h11);
    checkOutput("bp_valid", 32'(pValid), 32'b001);
    applyStimulus(1'b1, 8'h33, 3'b001, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("bp_pop_no_push_count", 32'(pCount), 32'd1);
    checkOutput("bp_head2", 32'(pDout), 32'h22);
    applyStimulus(1'b0, 8'h00, 3'b001, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("bp_push_pop_count", 32'(pCount), 32'd1);
    checkOutput("bp_head3", 32'(pDout), 32'h33);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("bp_drained", 32'(pCount), 32'd0);

    // Broadcast staggered acceptance of 0x5C by outputs 0, 2, then 1.
    qBc0.push_back(8'h5C); qBc1.push_back(8'h5C); qBc2.push_back(8'h5C);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 8'h5C, 3'b000, 1'b0);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b001, 1'b0);
    checkOutput("st_valid0", 32'(bValid), 32'b111);
    checkOutput("st_count", 32'(bCount), 32'd1);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b100, 1'b0);
    checkOutput("st_valid1", 32'(bValid), 32'b110);
    checkOutput("st_data", 32'(bDout), 32'h5C);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b010, 1'b0);
    checkOutput("st_valid2", 32'(bValid), 32'b010);
    checkOutput("st_count_hold", 32'(bCount), 32'd1);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("st_count_popped", 32'(bCount), 32'd0);
    checkOutput("st_valid_popped", 32'(bValid), 32'd0);

    // Broadcast throughput: eight back-to-back beats with all outputs ready.
    for (int i = 0; i < 8; i++) begin
      qBc0.push_back(8'(i)); qBc1.push_back(8'(i)); qBc2.push_back(8'(i));
      applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 8'(i), 3'b111, 1'b0);
      checkOutput($sformatf("tp_ready%0d", i), 32'(bRdyO), 32'd1);
      checkOutput($sformatf("tp_count%0d", i), 32'(bCount), (i == 0) ? 32'd0 : 32'd1);
    end
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b111, 1'b0);
    checkOutput("tp_last_data", 32'(bDout), 32'h07);
    checkOutput("tp_last_valid", 32'(bValid), 32'b111);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("tp_drained", 32'(bCount), 32'd0);

    // Clear with a partially delivered head and a full FIFO.
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 8'hA1, 3'b000, 1'b0);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 8'hA2, 3'b000, 1'b0);
    checkOutput("clr_count1", 32'(bCount), 32'd1);
    qBc1.push_back(8'hA1);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b010, 1'b0);
    checkOutput("clr_count2", 32'(bCount), 32'd2);
    checkOutput("clr_head", 32'(bDout), 32'hA1);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 8'hA3, 3'b000, 1'b1);
    checkOutput("clr_sent_valid", 32'(bValid), 32'b101);
    checkOutput("clr_full_count", 32'(bCount), 32'd2);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("clr_count", 32'(bCount), 32'd0);
    checkOutput("clr_valid", 32'(bValid), 32'd0);
    checkOutput("clr_ready", 32'(bRdyO), 32'd1);
    checkOutput("clr_data", 32'(bDout), 32'd0);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b111, 1'b0);
    checkOutput("clr_discarded", 32'(bCount), 32'd0);

    // Every queued expectation must have been consumed.
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0);
    checkOutput("pri_queue_left", 32'(qPri.size()), 32'd0);
    checkOutput("bc0_queue_left", 32'(qBc0.size()), 32'd0);
    checkOutput("bc1_queue_left", 32'(qBc1.size()), 32'd0);
    checkOutput("bc2_queue_left", 32'(qBc2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
